// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bridge: FSM encoding, address-map
// constant and the data word returned by an aborted peripheral access.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM,
    PERIPH,
    DONE
  } state_t;

  localparam logic [3:0]  PERIPH_BASE_NIBBLE = 4'hE;
  localparam logic [31:0] TIMEOUT_DATA       = 32'hDEAD_BEEF;

  function automatic logic is_periph(input logic [31:0] addr);
    return addr[31:28] >= PERIPH_BASE_NIBBLE;
  endfunction

endpackage

// File: rtl/mio_wdog.sv
// Peripheral-wait watchdog: counts no-ack cycles and flags expiry on the cycle
// whose increment would reach TIMEOUT_CYCLES. Only built under MIO_TIMEOUT_EN.
module mio_wdog
  import mio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mio_bridge.sv
// Load/store bridge between the core's data-memory port and on-chip RAM or
// the peripheral bus. Optional peripheral timeout enabled by MIO_TIMEOUT_EN.
module mio_bridge
  import mio_pkg::*;
#(
  parameter int          RAM_AW         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_wea,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_wea,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              periph_sel,
  output logic              periph_we,
  output logic [31:0]       periph_addr,
  output logic [31:0]       periph_wdata,
  input  logic [31:0]       periph_rdata,
  input  logic              periph_ack
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  wea_q;
  logic        we_q;
  logic        from_ram;
  logic        timeout;

`ifdef MIO_TIMEOUT_EN
  logic bus_err_q;

  mio_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != PERIPH),
    .enable (state == PERIPH && !periph_ack),
    .expired(timeout)
  );

  // Sticky until reset; an ack in the expiry cycle keeps timeout low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_err_q <= 1'b0;
    end else if (state == PERIPH && timeout) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wea_q    <= '0;
      we_q     <= 1'b0;
      from_ram <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            wea_q    <= cpu_wea;
            we_q     <= cpu_we;
            from_ram <= !is_periph(cpu_addr);
            state    <= is_periph(cpu_addr) ? PERIPH : RAM;
          end
        end
        RAM: begin
          state <= DONE;
        end
        PERIPH: begin
          if (periph_ack) begin
            rdata_q <= we_q ? 32'h0 : periph_rdata;
            state   <= DONE;
          end else if (timeout) begin
            rdata_q <= TIMEOUT_DATA;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Gating with rst drops a write whose cycle coincides with reset.
  assign ram_wea      = (state == RAM && we_q && rst) ? wea_q : 4'h0;
  assign ram_addr     = addr_q[RAM_AW+1:2];
  assign ram_din      = wdata_q;
  assign periph_sel   = (state == PERIPH);
  assign periph_we    = (state == PERIPH) && we_q;
  assign periph_addr  = addr_q;
  assign periph_wdata = wdata_q;
  assign cpu_ready    = (state == DONE);

  // The synchronous RAM read lands in the DONE cycle, so it is passed through.
  always_comb begin
    cpu_rdata = 32'h0;
    if (state == DONE) begin
      if (from_ram) begin
        cpu_rdata = we_q ? 32'h0 : ram_dout;
      end else begin
        cpu_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mio_bridge.sv
// Self-checking bench for mio_bridge: directed table, random transactions
// against a word-level memory model, and reset/back-to-back/timeout sequences.
module tb_mio_bridge;

  localparam int RAM_AW = 10;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [3:0]        cpu_wea = 4'h0;
  logic [31:0]       cpu_addr = 32'h0;
  logic [31:0]       cpu_wdata = 32'h0;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              bus_err;
  logic [RAM_AW-1:0] ram_addr;
  logic [3:0]        ram_wea;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout = 32'h0;
  logic              periph_sel;
  logic              periph_we;
  logic [31:0]       periph_addr;
  logic [31:0]       periph_wdata;
  logic [31:0]       periph_rdata = 32'h0;
  logic              periph_ack = 1'b0;

  mio_bridge #(.RAM_AW(RAM_AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wea(cpu_wea),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .bus_err(bus_err), .ram_addr(ram_addr),
    .ram_wea(ram_wea), .ram_din(ram_din), .ram_dout(ram_dout),
    .periph_sel(periph_sel), .periph_we(periph_we), .periph_addr(periph_addr),
    .periph_wdata(periph_wdata), .periph_rdata(periph_rdata), .periph_ack(periph_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_delay;
    logic [31:0] ack_data;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        got_ready;
    logic [31:0] rdata;
    int          lat;
    int          sel_cycles;
    int          writes;
    logic [9:0]  w_addr;
    logic [3:0]  w_wea;
    logic [31:0] w_din;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
  } obs_t;

  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          errors = 0;
  int          checks = 0;
  logic        exp_bus_err = 1'b0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Synchronous-read RAM sitting on the bridge's RAM port
  always @(posedge clk) begin
    ram_dout <= env_mem[ram_addr];
    if (ram_wea != 4'h0) env_mem[ram_addr] <= mergeBytes(env_mem[ram_addr], ram_din, ram_wea);
  end

  function automatic logic isPeriph(input logic [31:0] a);
    return a[31:28] >= 4'hE;
  endfunction

  function automatic logic [31:0] modelRead(input vec_t v);
    if (v.we) return 32'h0;
    if (isPeriph(v.addr)) return v.ack_data;
    return ref_mem[v.addr[11:2]];
  endfunction

  function automatic int modelLatency(input vec_t v);
    return isPeriph(v.addr) ? v.ack_delay + 1 : 2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output obs_t o);
    int sel_count;
    o.got_ready = 1'b0; o.rdata = '0; o.lat = 0; o.sel_cycles = 0; o.writes = 0;
    o.w_addr = '0; o.w_wea = '0; o.w_din = '0; o.p_we = 1'b0; o.p_addr = '0; o.p_wdata = '0;
    sel_count = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_wea = v.wea; cpu_addr = v.addr; cpu_wdata = v.wdata;
    for (int c = 1; c <= 40 && !o.got_ready; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_wea != 4'h0) begin
        o.writes++; o.w_addr = ram_addr; o.w_wea = ram_wea; o.w_din = ram_din;
      end
      if (periph_sel) begin
        sel_count++;
        o.p_we = periph_we; o.p_addr = periph_addr; o.p_wdata = periph_wdata;
      end
      o.sel_cycles = sel_count;
      periph_ack   = periph_sel && (sel_count == v.ack_delay);
      periph_rdata = periph_ack ? v.ack_data : ~v.ack_data;
      if (cpu_ready) begin
        o.got_ready = 1'b1; o.lat = c; o.rdata = cpu_rdata; cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    periph_ack = 1'b0;
  endtask

  task automatic checkTransaction(input vec_t v, input obs_t o, input logic [31:0] exp_rdata,
                                  input int exp_lat, input string tag);
    checkOutput({tag, ".ready"}, 32'(o.got_ready), 32'd1);
    checkOutput({tag, ".rdata"}, o.rdata, exp_rdata);
    checkOutput({tag, ".latency"}, o.lat, exp_lat);
    checkOutput({tag, ".bus_err"}, 32'(bus_err), 32'(exp_bus_err));
    if (!isPeriph(v.addr)) begin
      checkOutput({tag, ".ram_writes"}, o.writes, (v.we && v.wea != 4'h0) ? 1 : 0);
      checkOutput({tag, ".sel_cycles"}, o.sel_cycles, 0);
      if (v.we) begin
        checkOutput({tag, ".w_addr"}, 32'(o.w_addr), 32'(v.addr[11:2]));
        checkOutput({tag, ".w_wea"}, 32'(o.w_wea), 32'(v.wea));
        checkOutput({tag, ".w_din"}, o.w_din, v.wdata);
        ref_mem[v.addr[11:2]] = mergeBytes(ref_mem[v.addr[11:2]], v.wdata, v.wea);
      end
    end else begin
      checkOutput({tag, ".ram_writes"}, o.writes, 0);
      checkOutput({tag, ".sel_cycles"}, o.sel_cycles, v.ack_delay);
      checkOutput({tag, ".p_we"}, 32'(o.p_we), 32'(v.we));
      checkOutput({tag, ".p_addr"}, o.p_addr, v.addr);
      if (v.we) checkOutput({tag, ".p_wdata"}, o.p_wdata, v.wdata);
    end
  endtask

  task automatic runModel(input vec_t v, input string tag);
    obs_t o;
    logic [31:0] er;
    er = modelRead(v);
    applyStimulus(v, o);
    checkTransaction(v, o, er, modelLatency(v), tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; periph_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t        table_v [9];
  vec_t        v;
  obs_t        o;
  logic [31:0] mask;
  logic        ready_seen;
  logic [3:0]  nib;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    table_v[0] = '{we:1'b1, wea:4'hF, addr:32'h0000_0010, wdata:32'h1234_5678, ack_delay:0, ack_data:32'h0, exp_rdata:32'h0, exp_lat:2};
    table_v[1] = '{we:1'b0, wea:4'h0, addr:32'h0000_0010, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'h1234_5678, exp_lat:2};
    table_v[2] = '{we:1'b1, wea:4'b0100, addr:32'h0000_0022, wdata:32'hAABB_CCDD, ack_delay:0, ack_data:32'h0, exp_rdata:32'h0, exp_lat:2};
    table_v[3] = '{we:1'b0, wea:4'h0, addr:32'h0000_0020, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'h00BB_0000, exp_lat:2};
    table_v[4] = '{we:1'b0, wea:4'h0, addr:32'h1000_0010, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'h1234_5678, exp_lat:2};
    table_v[5] = '{we:1'b0, wea:4'h0, addr:32'hD000_0020, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'h00BB_0000, exp_lat:2};
    table_v[6] = '{we:1'b0, wea:4'h0, addr:32'hE000_0000, wdata:32'h0, ack_delay:3, ack_data:32'h0000_00AA, exp_rdata:32'h0000_00AA, exp_lat:4};
    table_v[7] = '{we:1'b1, wea:4'hF, addr:32'hF000_0004, wdata:32'h0000_0077, ack_delay:1, ack_data:32'h5555_5555, exp_rdata:32'h0, exp_lat:2};
    table_v[8] = '{we:1'b1, wea:4'b1001, addr:32'h0000_0FFC, wdata:32'hCAFE_F00D, ack_delay:0, ack_data:32'h0, exp_rdata:32'h0, exp_lat:2};

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    checkOutput("reset.cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset.cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("reset.bus_err", 32'(bus_err), 32'd0);
    checkOutput("reset.ram_wea", 32'(ram_wea), 32'd0);
    checkOutput("reset.periph_sel", 32'(periph_sel), 32'd0);
    checkOutput("reset.periph_we", 32'(periph_we), 32'd0);
    checkOutput("reset.ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("reset.periph_addr", periph_addr, 32'h0);
    checkOutput("reset.periph_wdata", periph_wdata, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(table_v[i], o);
      checkTransaction(table_v[i], o, table_v[i].exp_rdata, table_v[i].exp_lat, $sformatf("tbl%0d", i));
    end
    v = '{we:1'b0, wea:4'h0, addr:32'h7000_0FFC, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'hCA00_000D, exp_lat:2};
    applyStimulus(v, o);
    checkTransaction(v, o, v.exp_rdata, v.exp_lat, "top_word");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) nib = 4'($urandom_range(14, 15));
      else nib = 4'($urandom_range(0, 13));
      v.we        = 1'($urandom_range(0, 1));
      v.wea       = 4'($urandom_range(1, 15));
      v.addr      = {nib, 28'($urandom)};
      v.wdata     = $urandom;
      v.ack_delay = $urandom_range(1, TO);
      v.ack_data  = $urandom;
      runModel(v, $sformatf("rnd%0d", i));
    end

    // Request held through DONE is taken only after an idle cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    mask = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ready) mask[c] = 1'b1;
    end
    cpu_req = 1'b0;
    checkOutput("b2b.ready_pattern", mask, 32'h0000_0024);

    // Reset during a peripheral wait
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hE000_0100;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstp.sel_before", 32'(periph_sel), 32'd1);
    cpu_req = 1'b0; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstp.periph_sel", 32'(periph_sel), 32'd0);
    checkOutput("rstp.cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("rstp.periph_addr", periph_addr, 32'h0);
    rst = 1'b1; periph_ack = 1'b1; periph_rdata = 32'h0000_0099;
    ready_seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      periph_ack = 1'b0;
      if (cpu_ready || periph_sel) ready_seen = 1'b1;
    end
    checkOutput("rstp.late_ack_ignored", 32'(ready_seen), 32'd0);
    v = '{we:1'b0, wea:4'h0, addr:32'h0000_0010, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'h0, exp_lat:2};
    runModel(v, "rstp.ram_load");

    // Reset in the RAM cycle of a store suppresses the write
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wea = 4'hF; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstr.wea_before", 32'(ram_wea), 32'hF);
    cpu_req = 1'b0; rst = 1'b0;
    #1;
    checkOutput("rstr.wea_gated", 32'(ram_wea), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstr.cpu_ready", 32'(cpu_ready), 32'd0);
    rst = 1'b1;
    v.addr = 32'h0000_0040;
    runModel(v, "rstr.ram_load");

`ifdef MIO_TIMEOUT_EN
    v = '{we:1'b0, wea:4'h0, addr:32'hE000_0008, wdata:32'h0, ack_delay:TO, ack_data:32'h0000_1357, exp_rdata:32'h0000_1357, exp_lat:TO + 1};
    applyStimulus(v, o);
    checkTransaction(v, o, v.exp_rdata, v.exp_lat, "to_ack_wins");
    v = '{we:1'b0, wea:4'h0, addr:32'hF000_0004, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'hDEAD_BEEF, exp_lat:TO + 1};
    applyStimulus(v, o);
    checkOutput("to.rdata", o.rdata, 32'hDEAD_BEEF);
    checkOutput("to.latency", o.lat, TO + 1);
    checkOutput("to.sel_cycles", o.sel_cycles, TO);
    checkOutput("to.bus_err", 32'(bus_err), 32'd1);
    exp_bus_err = 1'b1;
    v = '{we:1'b0, wea:4'h0, addr:32'h0000_0010, wdata:32'h0, ack_delay:0, ack_data:32'h0, exp_rdata:32'h0, exp_lat:2};
    runModel(v, "to.sticky");
    doReset();
    exp_bus_err = 1'b0;
    @(negedge clk);
    checkOutput("to.cleared", 32'(bus_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mio_bridge.md
# mio_bridge

- Downstream neighbour of the five-stage pipeline core's data-memory port.
- Takes one load/store request at a time from the core.
- Decodes the address to on-chip data RAM or the memory-mapped peripheral bus, sequences the access and returns read data with a single-cycle `cpu_ready` pulse, which drives the core's `MIO_ready`.
- The core holds its MEM stage while a request is outstanding.

## Interface
Parameters:
- `RAM_AW`, 10 — data RAM word-address width (4 KiB).
- `TIMEOUT_CYCLES`, 255 — maximum peripheral wait before an aborted access; range 1..65535.

Ports:
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — reset, synchronous, active-low.
- `cpu_req` in 1 — request valid; held stable until `cpu_ready`.
- `cpu_we` in 1 — 1 = store, 0 = load.
- `cpu_wea` in 4 — byte write enables, from the core's `wea`.
- `cpu_addr` in 32 — byte address.
- `cpu_wdata` in 32 — store data.
- `cpu_rdata` out 32 — load data; valid while `cpu_ready` = 1.
- `cpu_ready` out 1 — one-cycle completion pulse.
- `bus_err` out 1 — sticky peripheral-timeout flag.
- `ram_addr` out RAM_AW — RAM word address.
- `ram_wea` out 4 — RAM byte write enables.
- `ram_din` out 32 — RAM write data.
- `ram_dout` in 32 — RAM read data, one-cycle synchronous read.
- `periph_sel` out 1 — peripheral cycle active.
- `periph_we` out 1 — peripheral write.
- `periph_addr` out 32 — peripheral byte address.
- `periph_wdata` out 32 — peripheral write data.
- `periph_rdata` in 32 — peripheral read data, valid with `periph_ack`.
- `periph_ack` in 1 — peripheral completion, one or more cycles after `periph_sel` rises.

## Operation
Address map:
- `cpu_addr[31:28]` ≥ 4'hE → peripheral.
- All other addresses → RAM at word `cpu_addr[RAM_AW+1:2]`. Upper bits are ignored (aliasing).

State machine (IDLE, RAM, PERIPH, DONE):
- **IDLE:** on `cpu_req` = 1, register addr/wdata/wea/we and go to RAM or PERIPH per the decode. Otherwise stay.
- **RAM:**
  - `ram_addr` and `ram_din` come from the registers; `ram_wea` = wea if we, else 0.
  - Exactly one cycle, then DONE.
  - DONE captures `ram_dout` for loads, 0 for stores.
- **PERIPH:**
  - `periph_sel` = 1 and the peripheral outputs are driven from the registers.
  - On `periph_ack` = 1: capture `periph_rdata` (0 for stores) and go to DONE.
- **DONE:** `cpu_ready` = 1 for exactly one cycle, then IDLE.

Other rules:
- `ram_wea` is 0 in every state except RAM.
- A RAM write is performed exactly once per store.
- Sub-word stores rely on `cpu_wea` only. The bridge does not shift or mask data.

## Timing
- Reset values: `cpu_ready` = 0, `cpu_rdata` = 0, `bus_err` = 0, `ram_wea` = 0, `periph_sel` = 0, `periph_we` = 0, all address/data outputs 0, state IDLE.
- RAM access: request seen in cycle 0 → RAM in cycle 1 → `cpu_ready` in cycle 2. Latency is 2 cycles for both loads and stores.
- Peripheral access: `periph_sel` rises in cycle 1. An ack seen in cycle N gives `cpu_ready` in cycle N+1. The minimum latency is 2 cycles.
- `periph_ack` outside PERIPH is ignored.
- Back-to-back requests: a request still asserted in the DONE cycle is not sampled. It is accepted in the following IDLE cycle, so there is at least one idle cycle between accesses.
- Reset asserted mid-access: the next edge forces IDLE and all outputs to their reset values.
  - `periph_sel` drops.
  - No pending `cpu_ready` is issued.
  - A RAM write scheduled for that cycle is suppressed.

## Configuration
Macro: `MIO_TIMEOUT_EN`.

Defined:
- A 16-bit counter clears on entry to PERIPH and increments each cycle `periph_ack` = 0.
- When it reaches `TIMEOUT_CYCLES`, the state goes to DONE with `cpu_rdata` = 32'hDEAD_BEEF and `bus_err` is set.
- `bus_err` clears only on reset.
- An ack arriving in the same cycle as the timeout wins: normal data is returned and no error is flagged.

Undefined:
- PERIPH waits indefinitely for `periph_ack`.
- `bus_err` is tied to 0 and no counter logic is present.

## Structure
- Package `mio_pkg` holds:
  - the state encoding;
  - the `PERIPH_BASE_NIBBLE` constant (4'hE);
  - the `TIMEOUT_DATA` constant (32'hDEAD_BEEF).
- Sub-module `mio_wdog` (counter, clear/enable inputs, `expired` output) is instantiated only under `MIO_TIMEOUT_EN`.
- Everything else stays in `mio_bridge`.

## Test plan
- RAM store then load:
  - Stimulus: store 0x1234_5678 to 0x0000_0010 with wea = 4'hF, then load from 0x0000_0010.
  - Response: `ram_wea` = 4'hF for one cycle at word 4; load returns 0x1234_5678; each `cpu_ready` appears 2 cycles after its request.
- Byte store:
  - Stimulus: wea = 4'b0100 at 0x0000_0022.
  - Response: `ram_wea` = 4'b0100 at word 8; no other RAM write.
- Peripheral read:
  - Stimulus: load from 0xE000_0000, ack after 3 cycles with data 0x0000_00AA.
  - Response: `periph_sel` high for 3 cycles; `cpu_rdata` = 0xAA one cycle after the ack; `bus_err` = 0.
- Timeout (with `MIO_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4):
  - Stimulus: load from 0xF000_0004 with no ack.
  - Response: `cpu_ready` with 0xDEAD_BEEF; `bus_err` = 1 and stays set until reset.
- Reset mid-access:
  - Stimulus: assert `rst` = 0 while in PERIPH.
  - Response: next cycle `periph_sel` = 0 and `cpu_ready` = 0; a late ack is ignored; a following RAM load completes normally.
